// File: rtl/s2p_pkg.sv
// Shared definitions for the s2p_rx serial receiver: FSM encoding, line levels, defaults.
// S2P_PARITY_EN adds the PARITY state between DATA and STOP.
package s2p_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DATA_BITS  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef S2P_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/s2p_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/s2p_rx.sv
// Oversampling serial receiver: start, DATA_BITS MSB first, stop; one-character holding register.
// Define S2P_PARITY_EN to expect an even-parity bit before the stop bit and expose parity_err.
module s2p_rx
  import s2p_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 framing_err,
`ifdef S2P_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun_err
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   line, line_prev;
  logic                   cnt_clr, cnt_inc, bit_clr, take_bit, take_stop;
  logic                   char_ok, load;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line)
  );

`ifdef S2P_PARITY_EN
  logic take_par, par_bit;
  assign char_ok = ((^shreg) == par_bit);
`else
  assign char_ok = 1'b1;
`endif

  assign load = take_stop && (line == STOP_BIT) && char_ok && (!rx_valid || rx_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    bit_clr   = 1'b0;
    take_bit  = 1'b0;
    take_stop = 1'b0;
`ifdef S2P_PARITY_EN
    take_par  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // A line still low after a frame (break) re-arms once it has stayed low a full bit time.
        if (line_prev == STOP_BIT && line == START_BIT) begin
          state_n = START;
          cnt_clr = 1'b1;
          bit_clr = 1'b1;
        end else if (line == STOP_BIT) begin
          cnt_clr = 1'b1;
        end else if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            state_n = START;
            cnt_clr = 1'b1;
            bit_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      START: begin
        if (sample_tick) begin
          if (cnt == HALF_LAST) begin
            cnt_clr = 1'b1;
            if (line == START_BIT) state_n = DATA;
            else                   state_n = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            take_bit = 1'b1;
            cnt_clr  = 1'b1;
            if (bit_idx == BIT_LAST) begin
`ifdef S2P_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            take_par = 1'b1;
            cnt_clr  = 1'b1;
            state_n  = STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (sample_tick) begin
          if (cnt == FULL_LAST) begin
            take_stop = 1'b1;
            cnt_clr   = 1'b1;
            state_n   = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      line_prev   <= STOP_BIT;
      data_out    <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err  <= 1'b0;
      par_bit     <= 1'b0;
`endif
    end else begin
      line_prev   <= line;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err  <= 1'b0;
      if (take_par) par_bit <= line;
      if (take_stop && line == STOP_BIT && !char_ok) parity_err <= 1'b1;
`endif
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (bit_clr)       bit_idx <= '0;
      else if (take_bit) bit_idx <= bit_idx + 1'b1;

      if (take_bit) shreg <= (shreg << 1) | DATA_BITS'(line);

      if (take_stop && line != STOP_BIT) framing_err <= 1'b1;
      if (take_stop && line == STOP_BIT && char_ok && !load) overrun_err <= 1'b1;

      if (load) begin
        data_out <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2p_rx.sv
// Self-checking bench for s2p_rx: directed frames plus random frames against a frame-level model.
module tb_s2p_rx;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;

  logic          clk, rst, sample_tick, serial_in, rx_ack;
  logic [DB-1:0] data_out;
  logic          rx_valid, framing_err, overrun_err;
`ifdef S2P_PARITY_EN
  logic          parity_err;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int            fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int            exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic          m_valid;
  logic [DB-1:0] m_data;

  s2p_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .serial_in   (serial_in),
    .rx_ack      (rx_ack),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
`ifdef S2P_PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun_err (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every fourth clock.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (framing_err === 1'b1) fe_cnt++;
      if (overrun_err === 1'b1) ov_cnt++;
`ifdef S2P_PARITY_EN
      if (parity_err === 1'b1) pe_cnt++;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".framing"},  32'(fe_cnt),   32'(exp_fe));
    check({tag, ".overrun"},  32'(ov_cnt),   32'(exp_ov));
`ifdef S2P_PARITY_EN
    check({tag, ".parity"},   32'(pe_cnt),   32'(exp_pe));
`endif
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (sample_tick !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  // Frame-level model: what the receiver must report for one complete frame.
  task automatic model_frame(input logic [DB-1:0] d, input logic par_good,
                             input logic stop, input logic ack);
    if (!stop) exp_fe++;
    else if (!par_good) exp_pe++;
    else if (!m_valid || ack) begin
      m_valid = 1'b1;
      m_data  = d;
      return;
    end else exp_ov++;
    if (ack) m_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par_good,
                            input logic stop, input logic ack_at_stop);
    serial_in = 1'b0;
    wait_ticks(OS);
    for (int i = DB - 1; i >= 0; i--) begin
      serial_in = d[i];
      wait_ticks(OS);
    end
`ifdef S2P_PARITY_EN
    serial_in = par_good ? ^d : ~^d;
    wait_ticks(OS);
`endif
    serial_in = stop;
    if (ack_at_stop) begin
      // The stop bit is sampled on the eighth tick into it; raise rx_ack for exactly that clock.
      wait_ticks(7);
      repeat (3) @(posedge clk);
      #2 rx_ack = 1'b1;
      @(posedge clk);
      #2 rx_ack = 1'b0;
      wait_ticks(OS / 2);
    end else begin
      wait_ticks(OS);
    end
    serial_in = 1'b1;
    wait_ticks(4);
`ifdef S2P_PARITY_EN
    model_frame(d, par_good, stop, ack_at_stop);
`else
    model_frame(d, 1'b1, stop, ack_at_stop);
`endif
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clk);
    #2 rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop, pg, ack;
    rst       = 1'b0;
    serial_in = 1'b1;
    rx_ack    = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;

    repeat (5) @(posedge clk);
    #2 check_all("reset");
    rst = 1'b1;
    wait_ticks(20);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_all("a5");
    ack_pulse();
    check_all("a5_ack");

    serial_in = 1'b0;
    wait_ticks(4);
    serial_in = 1'b1;
    wait_ticks(20);
    check_all("glitch");

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_ticks(40);
    check_all("framing");

    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    check_all("first_11");
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    check_all("overrun");
    ack_pulse();
    check_all("overrun_ack");

    serial_in = 1'b0;
    wait_ticks(OS);
    serial_in = 1'b1;
    wait_ticks(3 * OS);
    rst     = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    repeat (3) @(posedge clk);
    #2 check_all("mid_reset");
    rst = 1'b1;
    wait_ticks(20);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check_all("after_reset");
    ack_pulse();

    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h99, 1'b1, 1'b1, 1'b1);
    check_all("ack_vs_load");
    ack_pulse();
    check_all("ack_vs_load_clr");

`ifdef S2P_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    check_all("parity_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_all("parity_good");
    ack_pulse();
`endif

    for (int n = 0; n < 12; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pg   = ($urandom_range(0, 3) != 0);
      ack  = 1'(($urandom_range(0, 1)));
      send_frame(d, pg, stop, ack);
      check_all("random");
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
